// File: rtl/nes_pad_reader.sv
`default_nettype none
// ============================================================================
// Module   : nes_pad_reader
// Purpose  : Polls one NES-style serial game pad (latch / clock / data,
//            8 buttons, active-low serial data) once per frame tick and
//            presents each button as a registered active-high level.
//            Button levels only change in the single DONE cycle, so a
//            partially shifted frame is never visible downstream.
// Ports    : clk           - system clock (single clock domain)
//            reset         - synchronous reset, active-high
//            poll          - one-cycle start pulse, honoured only when idle
//            pad_data      - serial data from pad (active-low, asynchronous)
//            pad_latch     - latch strobe to pad
//            pad_clk       - shift clock to pad, idles low
//            busy          - high while a read is in progress
//            valid         - one-cycle pulse when the buttons update
//            button_*      - registered button levels, 1 = pressed
// Revision : 1.0 - initial release
// ============================================================================
module nes_pad_reader #(
  parameter int HALF_PERIOD = 150
) (
  input  logic clk,
  input  logic reset,
  input  logic poll,
  input  logic pad_data,
  output logic pad_latch,
  output logic pad_clk,
  output logic busy,
  output logic valid,
  output logic button_a,
  output logic button_b,
  output logic button_select,
  output logic button_start,
  output logic button_up,
  output logic button_down,
  output logic button_left,
  output logic button_right
);

  localparam int PHASE_W = $clog2(2 * HALF_PERIOD);
  localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(2 * HALF_PERIOD - 1);
  localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LATCH    = 3'd1,
    S_PULSE_HI = 3'd2,
    S_PULSE_LO = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [PHASE_W-1:0] phase;
  logic [3:0]         bit_idx;
  logic [7:0]         shift_reg;
  logic [1:0]         sync;
  logic               data_s;

  // Control strobes from the next-state logic
  logic               phase_clr;
  logic               sample_first;
  logic               step_bit;

  assign data_s = sync[1];

  // --------------------------------------------------------------------------
  // pad_data synchroniser; released line reads as 1
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], pad_data};
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    phase_clr    = 1'b0;
    sample_first = 1'b0;
    step_bit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (poll) begin
          state_next = S_LATCH;
          phase_clr  = 1'b1;
        end
      end
      S_LATCH: begin
        if (phase == LATCH_LAST) begin
          sample_first = 1'b1;
          phase_clr    = 1'b1;
          state_next   = S_PULSE_HI;
        end
      end
      S_PULSE_HI: begin
        if (phase == HALF_LAST) begin
          phase_clr  = 1'b1;
          state_next = S_PULSE_LO;
        end
      end
      S_PULSE_LO: begin
        if (phase == HALF_LAST) begin
          phase_clr = 1'b1;
          step_bit  = 1'b1;
          // The 8th pulse only flushes the pad; its low half ends the read
          if (bit_idx == 4'd8) begin
            state_next = S_DONE;
          end else begin
            state_next = S_PULSE_HI;
          end
        end
      end
      S_DONE: begin
        phase_clr  = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Phase counter, bit index and shift register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= '0;
      bit_idx   <= 4'd0;
      shift_reg <= 8'hFF;
    end else begin
      if (phase_clr || (state == S_IDLE)) begin
        phase <= '0;
      end else begin
        phase <= phase + PHASE_W'(1);
      end

      if (sample_first) begin
        shift_reg[0] <= data_s;
        bit_idx      <= 4'd1;
      end else if (step_bit) begin
        // Guard keeps the discarded flush sample (index 8) from aliasing
        // onto bit 0 through the 3-bit slice
        if (bit_idx <= 4'd7) begin
          shift_reg[bit_idx[2:0]] <= data_s;
        end
        bit_idx <= bit_idx + 4'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs: follow the current state one cycle later, buttons
  // load inverted from the shift register only in DONE
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pad_latch     <= 1'b0;
      pad_clk       <= 1'b0;
      busy          <= 1'b0;
      valid         <= 1'b0;
      button_a      <= 1'b0;
      button_b      <= 1'b0;
      button_select <= 1'b0;
      button_start  <= 1'b0;
      button_up     <= 1'b0;
      button_down   <= 1'b0;
      button_left   <= 1'b0;
      button_right  <= 1'b0;
    end else begin
      pad_latch <= (state == S_LATCH);
      pad_clk   <= (state == S_PULSE_HI);
      busy      <= (state != S_IDLE);
      valid     <= (state == S_DONE);
      if (state == S_DONE) begin
        button_a      <= ~shift_reg[0];
        button_b      <= ~shift_reg[1];
        button_select <= ~shift_reg[2];
        button_start  <= ~shift_reg[3];
        button_up     <= ~shift_reg[4];
        button_down   <= ~shift_reg[5];
        button_left   <= ~shift_reg[6];
        button_right  <= ~shift_reg[7];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nes_pad_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_nes_pad_reader
// Purpose  : Self-checking bench for nes_pad_reader with HALF_PERIOD = 4.
//            A 4021-style pad model serves the serial data; a timeline model
//            predicts every output each cycle, and directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nes_pad_reader;

  localparam int H      = 4;
  localparam int DONE_N = 18 * H + 1;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic poll     = 1'b0;
  logic pad_data = 1'b1;
  logic pad_latch, pad_clk, busy, valid;
  logic button_a, button_b, button_select, button_start;
  logic button_up, button_down, button_left, button_right;
  logic [7:0] btn;

  always #5 clk = ~clk;

  nes_pad_reader #(.HALF_PERIOD(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .poll         (poll),
    .pad_data     (pad_data),
    .pad_latch    (pad_latch),
    .pad_clk      (pad_clk),
    .busy         (busy),
    .valid        (valid),
    .button_a     (button_a),
    .button_b     (button_b),
    .button_select(button_select),
    .button_start (button_start),
    .button_up    (button_up),
    .button_down  (button_down),
    .button_left  (button_left),
    .button_right (button_right)
  );

  // Bit i of btn is button i in pad bit order (0 = A ... 7 = Right)
  assign btn = {button_right, button_left, button_down, button_up,
                button_start, button_select, button_b, button_a};

  int checks = 0;
  int errors = 0;
  int nprint = 0;

  // --------------------------------------------------------------------------
  // Pad model: parallel load while latched, shift on pad_clk rising edge
  // --------------------------------------------------------------------------
  logic [7:0] pad_pattern = 8'hFF;  // active-low, bit i = button i
  logic       hold_en     = 1'b0;
  logic       hold_val    = 1'b1;
  logic [7:0] pad_sr      = 8'hFF;
  logic       pclk_prev   = 1'b0;

  always @(negedge clk) begin
    if (pad_latch) pad_sr = pad_pattern;
    else if (pad_clk && !pclk_prev) pad_sr = {1'b1, pad_sr[7:1]};
    pclk_prev = pad_clk;
    pad_data  = hold_en ? hold_val : pad_sr[0];
  end

  // --------------------------------------------------------------------------
  // Timeline model: n counts edges since the accepted poll
  // --------------------------------------------------------------------------
  int         cyc     = 0;
  bit         active  = 1'b0;
  int         n       = 0;
  logic [7:0] raw     = 8'hFF;
  logic [7:0] exp_btn = 8'h00;
  bit         started = 1'b0;

  always @(posedge clk) begin
    bit idle_now;
    cyc = cyc + 1;
    if (reset) begin
      active  = 1'b0;
      n       = 0;
      exp_btn = 8'h00;
      started = 1'b1;
    end else begin
      idle_now = !active || (n >= DONE_N);
      if (active) begin
        n = n + 1;
        if (n == DONE_N) exp_btn = ~raw;
        if (n > DONE_N) active = 1'b0;
      end
      if (idle_now && poll) begin
        active = 1'b1;
        n      = 0;
        raw    = hold_en ? {8{hold_val}} : pad_pattern;
      end
    end
  end

  function automatic logic [11:0] expected();
    logic b, l, c, v;
    b = active && (n >= 1) && (n <= DONE_N);
    l = active && (n >= 1) && (n <= 2 * H);
    c = 1'b0;
    for (int k = 1; k <= 8; k++)
      if (active && (n >= 2 * k * H + 1) && (n <= (2 * k + 1) * H)) c = 1'b1;
    v = active && (n == DONE_N);
    return {b, l, c, v, exp_btn};
  endfunction

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [11:0] got, want;
    if (started) begin
      got  = {busy, pad_latch, pad_clk, valid, btn};
      want = expected();
      checks = checks + 1;
      if (got !== want) begin
        errors = errors + 1;
        if (nprint < 20) begin
          nprint = nprint + 1;
          $display("FAIL cycle_compare cyc=%0d got=%b exp=%b (busy,latch,clk,valid,btn)",
                   cyc, got, want);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Activity counters (only this process writes them)
  // --------------------------------------------------------------------------
  int   latch_cycles = 0, latch_rises = 0, pclk_rises = 0, pclk_hi = 0, valid_count = 0;
  logic latch_q = 1'b0, pclk_q = 1'b0;

  always @(negedge clk) begin
    if (pad_latch) latch_cycles = latch_cycles + 1;
    if (pad_latch && !latch_q) latch_rises = latch_rises + 1;
    if (pad_clk) pclk_hi = pclk_hi + 1;
    if (pad_clk && !pclk_q) pclk_rises = pclk_rises + 1;
    if (valid) valid_count = valid_count + 1;
    latch_q = pad_latch;
    pclk_q  = pad_clk;
  end

  int s_l, s_lr, s_r, s_h, s_v;

  task automatic snap();
    #1;
    s_l  = latch_cycles;
    s_lr = latch_rises;
    s_r  = pclk_rises;
    s_h  = pclk_hi;
    s_v  = valid_count;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic poll_pulse(output int p0);
    @(negedge clk) poll = 1'b1;
    @(negedge clk) poll = 1'b0;
    p0 = cyc;
  endtask

  task automatic wait_valid(input int p0, output int rel);
    rel = -1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        rel = cyc - p0;
        break;
      end
    end
  endtask

  int p0, rel;

  initial begin
    // 1: reset held 3 edges, poll asserted during reset must be dropped
    @(negedge clk) poll = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    poll  = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("s1_latch_during_reset", latch_cycles, 0);
    chk("s1_outputs_zero", int'({busy, pad_latch, pad_clk, valid, btn}), 0);

    // 2: only Right pressed
    pad_pattern = 8'h7F;
    snap();
    poll_pulse(p0);
    wait_valid(p0, rel);
    chk("s2_valid_cycle", rel, 73);
    chk("s2_buttons", int'(btn), 8'h80);
    repeat (3) @(negedge clk);
    #1;
    chk("s2_latch_cycles", latch_cycles - s_l, 8);
    chk("s2_pclk_pulses", pclk_rises - s_r, 8);
    chk("s2_pclk_high_cycles", pclk_hi - s_h, 32);
    chk("s2_valid_count", valid_count - s_v, 1);
    chk("s2_busy_after", int'(busy), 0);

    // 3: data held low (all pressed), then held high (none pressed)
    hold_en  = 1'b1;
    hold_val = 1'b0;
    poll_pulse(p0);
    wait_valid(p0, rel);
    chk("s3_all_pressed", int'(btn), 8'hFF);
    repeat (3) @(negedge clk);
    hold_val = 1'b1;
    poll_pulse(p0);
    wait_valid(p0, rel);
    chk("s3_none_pressed", int'(btn), 8'h00);
    repeat (3) @(negedge clk);
    hold_en = 1'b0;

    // 4: poll re-asserted at edge 10 of an active read is ignored
    pad_pattern = 8'h3C;
    snap();
    poll_pulse(p0);
    repeat (9) @(negedge clk);
    poll = 1'b1;
    @(negedge clk) poll = 1'b0;
    wait_valid(p0, rel);
    chk("s4_valid_cycle", rel, 73);
    chk("s4_buttons", int'(btn), 8'hC3);
    repeat (3) @(negedge clk);
    #1;
    chk("s4_latch_pulses", latch_rises - s_lr, 1);
    chk("s4_valid_count", valid_count - s_v, 1);

    // 5: Left held from previous frame until the DONE edge
    pad_pattern = 8'hBF;
    poll_pulse(p0);
    wait_valid(p0, rel);
    chk("s5_left_frame", int'(btn), 8'h40);
    repeat (3) @(negedge clk);
    pad_pattern = 8'hEE;
    poll_pulse(p0);
    repeat (72) @(negedge clk);
    chk("s5_left_at_72", int'(button_left), 1);
    chk("s5_valid_at_72", int'(valid), 0);
    @(negedge clk);
    chk("s5_valid_at_73", int'(valid), 1);
    chk("s5_buttons_at_73", int'(btn), 8'h11);
    repeat (3) @(negedge clk);

    // 6: reset at edge 30 of a read, then a fresh poll
    pad_pattern = 8'h5A;
    poll_pulse(p0);
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("s6_busy_after_reset", int'(busy), 0);
    chk("s6_buttons_after_reset", int'(btn), 0);
    chk("s6_latch_after_reset", int'(pad_latch), 0);
    snap();
    repeat (80) @(negedge clk);
    #1;
    chk("s6_no_valid", valid_count - s_v, 0);
    poll_pulse(p0);
    wait_valid(p0, rel);
    chk("s6_valid_cycle", rel, 73);
    chk("s6_buttons", int'(btn), 8'hA5);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
